// File: rtl/plot_seq_pkg.sv
// Shared types and constants for the plot sequencer: state encoding, player palette,
// fixed pixel colours and the 5x7 digit glyphs (bit 34 = top-left, row-major).
package plot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR1,
        PLAY,
        CLEAR2,
        WAIT_ORDER,
        GLYPH,
        END
    } seq_state_t;

    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;
    localparam int GLYPH_PIX = GLYPH_W * GLYPH_H;

    localparam logic [2:0] TIMER_COLOUR = 3'b111;
    localparam logic [2:0] CLEAR_COLOUR = 3'b000;

    localparam logic [2:0] PALETTE [0:7] = '{
        3'b001, 3'b010, 3'b100, 3'b110, 3'b011, 3'b101, 3'b111, 3'b001
    };

    // Entry d holds the glyph for digit d+1.
    localparam logic [34:0] DIGIT_BMP [0:7] = '{
        {5'b11100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b11111},
        {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
        {5'b11110, 5'b00001, 5'b00001, 5'b01110, 5'b00001, 5'b00001, 5'b11110},
        {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
        {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
        {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
        {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
        {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110}
    };

endpackage

// File: rtl/plot_seq_glyph_rom.sv
// Combinational digit glyph lookup: digit index d (glyph of d+1) and pixel p -> lit bit.
module plot_seq_glyph_rom
    import plot_seq_pkg::*;
(
    input  logic [2:0] digit,
    input  logic [5:0] pix,
    output logic       bit_on
);

    logic [34:0] bmp;
    logic [5:0]  idx;

    assign bmp    = DIGIT_BMP[digit];
    assign idx    = 6'd34 - pix;
    assign bit_on = bmp[idx];

endmodule

// File: rtl/plot_sequencer.sv
// Draw sequencer: clear, round-robin player/timer plotting, clear, ranked digit glyphs.
// Define PLOT_SEQ_CLEAR_PACE_EN to hold each clear pixel for CLEAR_WAIT+1 cycles.
module plot_sequencer
    import plot_seq_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int CLEAR_WAIT  = 7999,
    parameter int GLYPH_X0    = 33,
    parameter int GLYPH_Y0    = 36,
    parameter int PITCH_X     = 30,
    parameter int PITCH_Y     = 12
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             running,
    input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] pos,
    input  logic [X_W-1:0]                   timer_x,
    input  logic [3*NUM_PLAYERS-1:0]         ordered_colours,
    input  logic                             order_valid,
    output logic [X_W-1:0]                   x,
    output logic [Y_W-1:0]                   y,
    output logic [2:0]                       colour,
    output logic                             plot,
    output logic                             game_started,
    output logic                             done
);

    localparam int RANK_W = $clog2(NUM_PLAYERS);
    localparam int SLOT_W = $clog2(NUM_PLAYERS + 1);
    localparam int NSLOT  = 1 << RANK_W;

    seq_state_t                 state;
    logic [X_W-1:0]             cx, gbx;
    logic [Y_W-1:0]             cy, gby;
    logic [SLOT_W-1:0]          slot;
    logic [RANK_W-1:0]          grank;
    logic [5:0]                 gp;
    logic [2:0]                 gcol, grow;
    logic [3*NUM_PLAYERS-1:0]   col_lat;
    logic                       rom_bit, clr_emit, clr_adv;
    logic [RANK_W-1:0]          sidx;

    logic [X_W-1:0] px   [NSLOT];
    logic [Y_W-1:0] py   [NSLOT];
    logic [2:0]     pal  [NSLOT];
    logic [2:0]     rcol [NSLOT];

    for (genvar g = 0; g < NSLOT; g++) begin : g_unpack
        if (g < NUM_PLAYERS) begin : g_live
            assign px[g]   = pos[g*(X_W+Y_W)+Y_W +: X_W];
            assign py[g]   = pos[g*(X_W+Y_W) +: Y_W];
            assign pal[g]  = PALETTE[g];
            assign rcol[g] = col_lat[3*g +: 3];
        end else begin : g_pad
            assign px[g]   = '0;
            assign py[g]   = '0;
            assign pal[g]  = '0;
            assign rcol[g] = '0;
        end
    end

    assign sidx = slot[RANK_W-1:0];

    plot_seq_glyph_rom u_rom (
        .digit  (3'(grank)),
        .pix    (gp),
        .bit_on (rom_bit)
    );

`ifdef PLOT_SEQ_CLEAR_PACE_EN
    localparam int PACE_W = $clog2(CLEAR_WAIT + 2);
    logic [PACE_W-1:0] pace;

    // Free-runs only while clearing; wraps at the end of each hold so it is zero on entry.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            pace <= '0;
        else if (state == CLEAR1 || state == CLEAR2)
            pace <= (pace == PACE_W'(CLEAR_WAIT)) ? '0 : pace + 1'b1;
    end

    assign clr_emit = (pace == '0);
    assign clr_adv  = (pace == PACE_W'(CLEAR_WAIT));
`else
    assign clr_emit = 1'b1;
    assign clr_adv  = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            game_started <= 1'b0;
            done         <= 1'b0;
            cx           <= '0;
            cy           <= '0;
            slot         <= '0;
            grank        <= '0;
            gp           <= '0;
            gcol         <= '0;
            grow         <= '0;
            gbx          <= '0;
            gby          <= '0;
            col_lat      <= '0;
        end else begin
            case (state)
                IDLE, END: begin
                    plot <= 1'b0;
                    done <= (state == END);
                    if (start) begin
                        state        <= CLEAR1;
                        cx           <= '0;
                        cy           <= '0;
                        done         <= 1'b0;
                        game_started <= 1'b0;
                    end
                end
                CLEAR1, CLEAR2: begin
                    plot <= clr_emit;
                    if (clr_emit) begin
                        x      <= cx;
                        y      <= cy;
                        colour <= CLEAR_COLOUR;
                    end
                    if (clr_adv) begin
                        if (cy == Y_W'(HEIGHT - 1)) begin
                            cy <= '0;
                            if (cx == X_W'(WIDTH - 1)) begin
                                cx    <= '0;
                                slot  <= '0;
                                state <= (state == CLEAR1) ? PLAY : WAIT_ORDER;
                            end else begin
                                cx <= cx + 1'b1;
                            end
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    plot         <= 1'b1;
                    game_started <= 1'b1;
                    if (slot == SLOT_W'(NUM_PLAYERS)) begin
                        x      <= timer_x;
                        y      <= Y_W'(HEIGHT - 1);
                        colour <= TIMER_COLOUR;
                        slot   <= '0;
                        if (!running)
                            state <= CLEAR2;
                    end else begin
                        x      <= px[sidx];
                        y      <= py[sidx];
                        colour <= pal[sidx];
                        slot   <= slot + 1'b1;
                    end
                end
                WAIT_ORDER: begin
                    plot <= 1'b0;
                    if (order_valid) begin
                        col_lat <= ordered_colours;
                        state   <= GLYPH;
                        grank   <= '0;
                        gp      <= '0;
                        gcol    <= '0;
                        grow    <= '0;
                        gbx     <= X_W'(GLYPH_X0);
                        gby     <= Y_W'(GLYPH_Y0);
                    end
                end
                GLYPH: begin
                    plot   <= 1'b1;
                    x      <= gbx + X_W'(gcol);
                    y      <= gby + Y_W'(grow);
                    colour <= rom_bit ? rcol[grank] : CLEAR_COLOUR;
                    // Rank is the inner loop; rank bases accumulate instead of multiplying.
                    if (grank == RANK_W'(NUM_PLAYERS - 1)) begin
                        grank <= '0;
                        gbx   <= X_W'(GLYPH_X0);
                        gby   <= Y_W'(GLYPH_Y0);
                        if (gp == 6'(GLYPH_PIX - 1)) begin
                            state <= END;
                        end else begin
                            gp <= gp + 1'b1;
                            if (gcol == 3'(GLYPH_W - 1)) begin
                                gcol <= '0;
                                grow <= grow + 1'b1;
                            end else begin
                                gcol <= gcol + 1'b1;
                            end
                        end
                    end else begin
                        grank <= grank + 1'b1;
                        gbx   <= gbx + X_W'(PITCH_X);
                        gby   <= gby + Y_W'(PITCH_Y);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sequencer.sv
// Directed bench for plot_sequencer (default, unpaced build).
module tb_plot_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        running = 1'b0;
    logic [59:0] pos = '0;
    logic [7:0]  timer_x = '0;
    logic [11:0] ordered_colours = '0;
    logic        order_valid = 1'b0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, game_started, done;

    int errs = 0;
    int checks = 0;

    plot_sequencer dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .start           (start),
        .running         (running),
        .pos             (pos),
        .timer_x         (timer_x),
        .ordered_colours (ordered_colours),
        .order_valid     (order_valid),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .game_started    (game_started),
        .done            (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix(input int px, input int py, input int c, input int p);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = 8'(px);
        yy = 7'(py);
        cc = 3'(c);
        return {13'b0, xx, yy, cc, p[0]};
    endfunction

    function automatic logic [31:0] obs();
        return {13'b0, x, y, colour, plot};
    endfunction

    // Caller sits on the negedge before the first clear pixel's edge.
    task automatic clear_scan(input string tag);
        int n_plot;
        n_plot = 0;
        for (int n = 0; n < 19200; n++) begin
            @(negedge CLOCK_50);
            if (plot) n_plot++;
            if (n == 0)     check({tag, "_first"}, obs(), pix(0, 0, 0, 1));
            if (n == 120)   check({tag, "_n120"}, obs(), pix(1, 0, 0, 1));
            if (n == 19199) check({tag, "_last"}, obs(), pix(159, 119, 0, 1));
        end
        check({tag, "_plot_cnt"}, n_plot, 19200);
    endtask

    logic [31:0] play_exp [5];
    logic [31:0] glyph_exp;
    int cnt;

    initial begin
        play_exp[0] = pix(10, 20, 3'b001, 1);
        play_exp[1] = pix(30, 40, 3'b010, 1);
        play_exp[2] = pix(50, 60, 3'b100, 1);
        play_exp[3] = pix(70, 80, 3'b110, 1);
        play_exp[4] = pix(5, 119, 3'b111, 1);

        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("reset_pix", obs(), 0);
        check("reset_flags", {game_started, done}, 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (plot) cnt++;
        end
        check("idle_plot_cnt", cnt, 0);

        pos = {8'd70, 7'd80, 8'd50, 7'd60, 8'd30, 7'd40, 8'd10, 7'd20};
        timer_x = 8'd5;
        running = 1'b1;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("start_lag", plot, 0);
        clear_scan("clear1");

        @(negedge CLOCK_50);
        check("game_started", game_started, 1);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("play_%0d", j), obs(), play_exp[j % 5]);
            @(negedge CLOCK_50);
        end
        @(negedge CLOCK_50);
        check("drop_slot1", obs(), play_exp[1]);
        running = 1'b0;
        for (int j = 2; j < 5; j++) begin
            @(negedge CLOCK_50);
            check($sformatf("tail_%0d", j), obs(), play_exp[j]);
        end
        clear_scan("clear2");

        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (plot) cnt++;
        end
        check("wait_plot_cnt", cnt, 0);
        check("wait_started", game_started, 1);

        ordered_colours = {3'b110, 3'b100, 3'b010, 3'b001};
        order_valid = 1'b1;
        @(negedge CLOCK_50);
        check("glyph_lag", plot, 0);
        cnt = 0;
        for (int n = 0; n < 140; n++) begin
            @(negedge CLOCK_50);
            if (plot) cnt++;
            glyph_exp = '1;
            case (n)
                0:   glyph_exp = pix(33, 36, 3'b001, 1);
                1:   glyph_exp = pix(63, 48, 3'b000, 1);
                2:   glyph_exp = pix(93, 60, 3'b100, 1);
                3:   glyph_exp = pix(123, 72, 3'b000, 1);
                4:   glyph_exp = pix(34, 36, 3'b001, 1);
                139: glyph_exp = pix(127, 78, 3'b000, 1);
                default: ;
            endcase
            if (glyph_exp != '1) check($sformatf("glyph_%0d", n), obs(), glyph_exp);
        end
        check("glyph_cnt", cnt, 140);
        @(negedge CLOCK_50);
        check("end_done", done, 1);
        check("end_hold", obs(), pix(127, 78, 0, 0));
        @(negedge CLOCK_50);
        check("end_done2", {done, game_started, plot}, 3'b110);

        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("restart_flags", {done, game_started, plot}, 3'b000);
        clear_scan("clear1b");
        @(negedge CLOCK_50);
        check("restart_play", obs(), play_exp[0]);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {plot, game_started, done}, 3'b000);
        check("async_reset_pix", obs(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
